// File: rtl/fft_pkg.sv
// Shared FFT pipeline constants and the bundle-feeder state type.
package fft_pkg;

   localparam int WIDTH  = 9;
   localparam int DEPTH  = 16;
   localparam int OFFSET = DEPTH / 2;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } feed_state_e;

endpackage

// File: rtl/bf2_bundle_feeder.sv
// Serial-to-bundle feeder for the radix-2 butterfly: collects DEPTH samples into
// a fill bank, then hands them to a registered output bank for the butterfly.
module bf2_bundle_feeder #(
   parameter int WIDTH = fft_pkg::WIDTH,
   parameter int DEPTH = fft_pkg::DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [WIDTH-1:0]       s_R,
   input  logic signed [WIDTH-1:0]       s_Q,
   input  logic                          s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DEPTH-1:0][WIDTH-1:0]   m_R,
   output logic [DEPTH-1:0][WIDTH-1:0]   m_Q,
   output logic                          m_en,
   output logic                          m_last
);
   import fft_pkg::*;

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   feed_state_e                 state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [DEPTH-1:0][WIDTH-1:0] fill_r_q, fill_r_d, fill_i_q, fill_i_d;
   logic                        fill_last_q, fill_last_d;
   logic [DEPTH-1:0][WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
   logic                        out_valid_q, out_valid_d;
   logic                        out_last_q, out_last_d;

   logic                        accept_s, complete_s, m_en_s;
   logic [DEPTH-1:0][WIDTH-1:0] bank_r_s, bank_i_s;

   assign s_ready = (state_q == FILL);
   assign m_en_s  = out_valid_q && m_ready;
   assign m_en    = m_en_s;
   assign m_valid = out_valid_q;
   assign m_last  = out_last_q;
   assign m_R     = out_r_q;
   assign m_Q     = out_i_q;

   // Next-state: lane writes, bundle completion and fill-to-output transfer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      fill_r_d    = fill_r_q;
      fill_i_d    = fill_i_q;
      fill_last_d = fill_last_q;
      out_r_d     = out_r_q;
      out_i_d     = out_i_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !m_en_s;

      accept_s   = s_valid && (state_q == FILL);
      complete_s = accept_s && (s_last || (idx_q == LAST_IDX));
      bank_r_s   = fill_r_q;
      bank_i_s   = fill_i_q;
      if (accept_s) begin
         bank_r_s[idx_q] = s_R;
         bank_i_s[idx_q] = s_Q;
      end else begin
         bank_r_s = fill_r_q;
         bank_i_s = fill_i_q;
      end

      case (state_q)
         FILL: begin
            if (complete_s) begin
               idx_d = '0;
               // Fill bank is cleared on every transfer, so unused lanes after an early s_last are already zero.
               if (!out_valid_q || m_en_s) begin
                  out_r_d     = bank_r_s;
                  out_i_d     = bank_i_s;
                  out_last_d  = s_last;
                  out_valid_d = 1'b1;
                  fill_r_d    = '0;
                  fill_i_d    = '0;
                  fill_last_d = 1'b0;
               end else begin
                  fill_r_d    = bank_r_s;
                  fill_i_d    = bank_i_s;
                  fill_last_d = s_last;
                  state_d     = FULL;
               end
            end else if (accept_s) begin
               fill_r_d = bank_r_s;
               fill_i_d = bank_i_s;
               idx_d    = idx_q + IW'(1);
            end else begin
               idx_d = idx_q;
            end
         end
         FULL: begin
            if (m_en_s) begin
               out_r_d     = fill_r_q;
               out_i_d     = fill_i_q;
               out_last_d  = fill_last_q;
               out_valid_d = 1'b1;
               fill_r_d    = '0;
               fill_i_d    = '0;
               fill_last_d = 1'b0;
               state_d     = FILL;
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State register with asynchronous clear of both banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         fill_r_q    <= '0;
         fill_i_q    <= '0;
         fill_last_q <= 1'b0;
         out_r_q     <= '0;
         out_i_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         fill_r_q    <= fill_r_d;
         fill_i_q    <= fill_i_d;
         fill_last_q <= fill_last_d;
         out_r_q     <= out_r_d;
         out_i_q     <= out_i_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_bf2_bundle_feeder.sv
// Self-checking bench: queue-based bundle model plus directed literal cases.
module tb_bf2_bundle_feeder;

   localparam int W = 9;
   localparam int D = 16;

   typedef struct {
      logic [D-1:0][W-1:0] r;
      logic [D-1:0][W-1:0] q;
      logic                last;
   } bundle_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic signed [W-1:0] s_R = '0;
   logic signed [W-1:0] s_Q = '0;
   logic                s_last = 1'b0;
   logic                m_valid;
   logic                m_ready = 1'b0;
   logic [D-1:0][W-1:0] m_R;
   logic [D-1:0][W-1:0] m_Q;
   logic                m_en;
   logic                m_last;

   int checks = 0;
   int errors = 0;
   int consumed = 0;

   bundle_t  exp_q[$];
   logic [W-1:0] part_r[D];
   logic [W-1:0] part_q[D];
   int part_n = 0;

   bf2_bundle_feeder #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_R(s_R), .s_Q(s_Q), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_R(m_R), .m_Q(m_Q),
      .m_en(m_en), .m_last(m_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [D-1:0][W-1:0] ramp(input int base, input int step, input int n);
      ramp = '0;
      for (int k = 0; k < n; k++) ramp[k] = W'(base + k * step);
   endfunction

   // Reference model: pending bundles are a queue; ready while fewer than two are held.
   always @(negedge clk) begin
      bundle_t b;
      int      held;
      if (!rst_n) begin
         exp_q.delete();
         part_n = 0;
         check("rst_s_ready", s_ready, 1);
         check("rst_m_valid", m_valid, 0);
         check("rst_m_last", m_last, 0);
         check("rst_m_R", m_R, 0);
         check("rst_m_Q", m_Q, 0);
      end else begin
         held = exp_q.size();
         check("mdl_s_ready", s_ready, (held < 2) ? 1 : 0);
         check("mdl_m_valid", m_valid, (held > 0) ? 1 : 0);
         check("mdl_m_en", m_en, ((held > 0) && m_ready) ? 1 : 0);
         if (held > 0) begin
            check("mdl_m_R", m_R, exp_q[0].r);
            check("mdl_m_Q", m_Q, exp_q[0].q);
            check("mdl_m_last", m_last, exp_q[0].last);
            if (m_ready) begin
               void'(exp_q.pop_front());
               consumed++;
            end
         end
         if (s_valid && (held < 2)) begin
            part_r[part_n] = s_R;
            part_q[part_n] = s_Q;
            part_n++;
            if (s_last || part_n == D) begin
               b.r = '0;
               b.q = '0;
               for (int k = 0; k < part_n; k++) begin
                  b.r[k] = part_r[k];
                  b.q[k] = part_q[k];
               end
               b.last = s_last;
               exp_q.push_back(b);
               part_n = 0;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Offer one sample from posedge+1; returns at posedge+1 after it was accepted.
   task automatic send(input int r, input int q, input bit l);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_R = W'(r);
      s_Q = W'(q);
      s_last = l;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 1, 0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   initial begin
      int cyc;
      int base;
      int sv_duty;
      int mr_duty;
      do_reset();

      // One full bundle with m_ready high.
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(i, -i, 1'b0);
      check("b1_m_valid", m_valid, 1);
      check("b1_m_en", m_en, 1);
      check("b1_m_R", m_R, ramp(0, 1, 16));
      check("b1_m_Q", m_Q, ramp(0, -1, 16));
      check("b1_m_last", m_last, 0);
      @(posedge clk); #1;
      check("b1_m_valid_clear", m_valid, 0);

      // Back-to-back: m_valid only in the cycle after accepts 16 and 32.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         send(i, -i, 1'b0);
         check("bb_m_valid", m_valid, (i == 15 || i == 31) ? 1 : 0);
      end
      @(posedge clk); #1;

      // Back-pressure: second bundle parks in the fill bank, input stalls.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 32; i++) send(i, -i, 1'b0);
      check("bp_s_ready", s_ready, 0);
      check("bp_held_R", m_R, ramp(0, 1, 16));
      m_ready = 1'b1;
      #1;
      check("bp_m_en", m_en, 1);
      @(posedge clk); #1;
      check("bp_second_valid", m_valid, 1);
      check("bp_second_R", m_R, ramp(16, 1, 16));
      check("bp_s_ready_back", s_ready, 1);
      @(posedge clk); #1;
      check("bp_drained", m_valid, 0);

      // Early s_last in lane 5 pads with zeros; next sample restarts at lane 0.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(i + 1, 0, i == 5);
      check("el_m_R", m_R, ramp(1, 1, 6));
      check("el_m_last", m_last, 1);
      send(7, 0, 1'b1);
      check("el_next_R", m_R, ramp(7, 1, 1));
      @(posedge clk); #1;

      // Reset mid-bundle discards the partial fill.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 7; i++) send(50 + i, 7, 1'b0);
      do_reset();
      for (int i = 0; i < 16; i++) send(100 + i, 0, 1'b0);
      check("rs_m_R", m_R, ramp(100, 1, 16));
      check("rs_m_Q", m_Q, 0);
      @(posedge clk); #1;

      // Random traffic against the model for 1000 bundles.
      do_reset();
      base = consumed;
      cyc = 0;
      sv_duty = 70;
      mr_duty = 60;
      while ((consumed - base) < 1000 && cyc < 60000) begin
         if ((cyc % 256) == 0) begin
            sv_duty = $urandom_range(30, 100);
            mr_duty = $urandom_range(10, 100);
         end
         s_valid = ($urandom_range(0, 99) < sv_duty);
         s_R = W'($urandom);
         s_Q = W'($urandom);
         s_last = ($urandom_range(0, 15) == 0);
         m_ready = ($urandom_range(0, 99) < mr_duty);
         @(posedge clk); #1;
         cyc++;
      end
      check("rand_bundles_done", ((consumed - base) >= 1000) ? 1 : 0, 1);
      s_valid = 1'b0;
      s_last = 1'b0;
      m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_drain_valid", m_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
